// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the DataMemory arbiter: priority FSM encoding,
// requester port indices and the wait-counter width function.
package dmem_arb_pkg;

    typedef enum logic {
        CPU_PRI = 1'b0,
        DMA_PRI = 1'b1
    } prio_state_t;

    localparam int PORT_C = 0;
    localparam int PORT_D = 1;

    // Ceiling log2, never narrower than one bit.
    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/dmem_arbiter_aging_ctr.sv
// Aging counter and priority FSM for the DMA port: counts consecutive cycles
// the DMA loses and hands it priority for one contested cycle at MAX_WAIT.
module arb_aging_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_req,
    input  logic             d_gnt,
    output logic             prio_d,
    output logic [CNT_W-1:0] d_wait_cnt
);

    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    prio_state_t      r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_nxt;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the signal unassigned and a latch is inferred.
        w_wait_nxt = '0;
        if (d_req && !d_gnt) begin
            w_wait_nxt = (r_wait_cnt == WAIT_MAX) ? WAIT_MAX : r_wait_cnt + CNT_W'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= CPU_PRI;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            case (r_state)
                CPU_PRI: if (w_wait_nxt == WAIT_MAX) r_state <= DMA_PRI;
                DMA_PRI: if (d_gnt || !d_req)        r_state <= CPU_PRI;
                default:                             r_state <= CPU_PRI;
            endcase
        end
    end

    assign prio_d     = (r_state == DMA_PRI);
    assign d_wait_cnt = r_wait_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory: MEM stage (c) has
// priority, DMA (d) ages in. Define DMEM_ARB_STATS_EN to add grant/conflict counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_c_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_conflicts
`endif
);

    localparam int CNT_W = clog2(MAX_WAIT + 1);

    logic             w_prio_d;
    logic [CNT_W-1:0] w_wait_cnt_unused;
    logic [1:0]       w_gnt;

    logic              r_c_rvalid;
    logic [DATA_W-1:0] r_c_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;

    arb_aging_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_aging (
        .clk        (clk),
        .reset      (reset),
        .d_req      (d_req),
        .d_gnt      (w_gnt[PORT_D]),
        .prio_d     (w_prio_d),
        .d_wait_cnt (w_wait_cnt_unused)
    );

    always_comb begin
        w_gnt     = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_req && d_req) begin
            w_gnt[PORT_D] = w_prio_d;
            w_gnt[PORT_C] = !w_prio_d;
        end else begin
            w_gnt[PORT_C] = c_req;
            w_gnt[PORT_D] = d_req;
        end
        if (w_gnt[PORT_C]) begin
            mem_read  = !c_we;
            mem_write = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (w_gnt[PORT_D]) begin
            mem_read  = !d_we;
            mem_write = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the read-data registers are reset too, so a port never exposes stale data after reset.
            r_c_rvalid <= 1'b0;
            r_c_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_c_rvalid <= w_gnt[PORT_C] && !c_we;
            r_d_rvalid <= w_gnt[PORT_D] && !d_we;
            if (w_gnt[PORT_C] && !c_we) r_c_rdata <= mem_rdata;
            if (w_gnt[PORT_D] && !d_we) r_d_rdata <= mem_rdata;
        end
    end

    assign c_gnt    = w_gnt[PORT_C];
    assign d_gnt    = w_gnt[PORT_D];
    assign c_stall  = c_req && !w_gnt[PORT_C];
    assign c_rvalid = r_c_rvalid;
    assign c_rdata  = r_c_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_stat_c_grants;
    logic [31:0] r_stat_d_grants;
    logic [31:0] r_stat_conflicts;

    // Free-running counters; wrap-around on overflow is intended.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_c_grants  <= '0;
            r_stat_d_grants  <= '0;
            r_stat_conflicts <= '0;
        end else begin
            if (w_gnt[PORT_C])  r_stat_c_grants  <= r_stat_c_grants + 32'd1;
            if (w_gnt[PORT_D])  r_stat_d_grants  <= r_stat_d_grants + 32'd1;
            if (c_req && d_req) r_stat_conflicts <= r_stat_conflicts + 32'd1;
        end
    end

    assign stat_c_grants  = r_stat_c_grants;
    assign stat_d_grants  = r_stat_d_grants;
    assign stat_conflicts = r_stat_conflicts;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model with its own memory image.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              c_req, c_we, d_req, d_we;
    logic [ADDR_W-1:0] c_addr, d_addr;
    logic [DATA_W-1:0] c_wdata, d_wdata;
    logic              c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid;
    logic [DATA_W-1:0] c_rdata, d_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]       stat_c_grants, stat_d_grants, stat_conflicts;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .c_stall   (c_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_c_grants  (stat_c_grants),
        .stat_d_grants  (stat_d_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    // DataMemory stand-in: 16 words, combinational read, write at the clock edge.
    logic [DATA_W-1:0] dmem [0:15];
    assign mem_rdata = dmem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_write) dmem[mem_addr[5:2]] <= mem_wdata;
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [0:15];
    int                losses;
    bit                m_c_gnt, m_d_gnt;
    bit                exp_c_rvalid, exp_d_rvalid;
    logic [DATA_W-1:0] exp_c_rdata, exp_d_rdata;
    int unsigned       exp_stat_c, exp_stat_d, exp_stat_x;
    int                n_c_gnt, n_d_gnt, n_stall;
    logic [9:0]        d_win_pattern;
    int                cyc_idx;
    int                checks, errors;

    bit                c_pend, d_pend;
    logic              c_w, d_w;
    logic [ADDR_W-1:0] c_a, d_a;
    logic [DATA_W-1:0] c_d, d_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                         input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    // One clock: check grant/memory drive mid-cycle, then registered outputs after the edge.
    task automatic cycle();
        bit                exp_rd, exp_wr;
        logic [ADDR_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_wd;
        @(negedge clk);
        m_c_gnt = c_req && !(d_req && losses >= MAX_WAIT);
        m_d_gnt = d_req && !m_c_gnt;
        exp_rd = 1'b0; exp_wr = 1'b0; exp_a = '0; exp_wd = '0;
        if (m_c_gnt) begin
            exp_rd = !c_we; exp_wr = c_we; exp_a = c_addr; exp_wd = c_wdata;
        end else if (m_d_gnt) begin
            exp_rd = !d_we; exp_wr = d_we; exp_a = d_addr; exp_wd = d_wdata;
        end
        check("c_gnt", c_gnt, m_c_gnt);
        check("d_gnt", d_gnt, m_d_gnt);
        check("c_stall", c_stall, c_req && !m_c_gnt);
        check("mem_read", mem_read, exp_rd);
        check("mem_write", mem_write, exp_wr);
        check("mem_addr", mem_addr, exp_a);
        check("mem_wdata", mem_wdata, exp_wd);
        n_c_gnt += int'(c_gnt);
        n_d_gnt += int'(d_gnt);
        n_stall += int'(c_stall);
        if (cyc_idx < 10) d_win_pattern[cyc_idx] = d_gnt;
        cyc_idx++;
        @(posedge clk);
        #1;
        if (reset) begin
            exp_c_rvalid = 1'b0; exp_c_rdata = '0;
            exp_d_rvalid = 1'b0; exp_d_rdata = '0;
            losses = 0;
            exp_stat_c = 0; exp_stat_d = 0; exp_stat_x = 0;
        end else begin
            exp_c_rvalid = m_c_gnt && !c_we;
            exp_d_rvalid = m_d_gnt && !d_we;
            if (exp_c_rvalid) exp_c_rdata = ref_mem[c_addr[5:2]];
            if (exp_d_rvalid) exp_d_rdata = ref_mem[d_addr[5:2]];
            if (d_req && !m_d_gnt) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
            else                   losses = 0;
            exp_stat_c += int'(m_c_gnt);
            exp_stat_d += int'(m_d_gnt);
            exp_stat_x += int'(c_req && d_req);
        end
        if (m_c_gnt && c_we) ref_mem[c_addr[5:2]] = c_wdata;
        if (m_d_gnt && d_we) ref_mem[d_addr[5:2]] = d_wdata;
        check("c_rvalid", c_rvalid, exp_c_rvalid);
        check("c_rdata", c_rdata, exp_c_rdata);
        check("d_rvalid", d_rvalid, exp_d_rvalid);
        check("d_rdata", d_rdata, exp_d_rdata);
`ifdef DMEM_ARB_STATS_EN
        check("stat_c_grants", stat_c_grants, exp_stat_c);
        check("stat_d_grants", stat_d_grants, exp_stat_d);
        check("stat_conflicts", stat_conflicts, exp_stat_x);
`endif
    endtask

    initial begin
        checks = 0; errors = 0; losses = 0; cyc_idx = 0;
        exp_c_rvalid = 0; exp_d_rvalid = 0; exp_c_rdata = '0; exp_d_rdata = '0;
        exp_stat_c = 0; exp_stat_d = 0; exp_stat_x = 0;
        n_c_gnt = 0; n_d_gnt = 0; n_stall = 0; d_win_pattern = '0;
        for (int i = 0; i < 16; i++) begin
            dmem[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        reset = 1'b0;

        // Port c alone: write then read back.
        drive(1, 1, 32'h4, 32'h1111_1111, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 32'h4, 32'h0, 0, 0, 0, 0);
        cycle();
        check("c_read_0x4", c_rdata, 32'h1111_1111);

        // Port d alone: write then read back.
        drive(0, 0, 0, 0, 1, 1, 32'h8, 32'h2222_2222);
        cycle();
        drive(0, 0, 0, 0, 1, 0, 32'h8, 32'h0);
        cycle();
        check("d_read_0x8", d_rdata, 32'h2222_2222);

        // Reset lands on a granted d read: its rvalid must be dropped.
        reset = 1'b1;
        cycle();
        check("rst_d_rvalid", d_rvalid, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        reset = 1'b0;
        check("rst_c_rdata", c_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);

        // Continuous contention: d must win exactly on every fifth cycle.
        n_c_gnt = 0; n_d_gnt = 0; n_stall = 0; cyc_idx = 0;
        drive(1, 0, 32'h4, 32'h0, 1, 0, 32'h8, 32'h0);
        for (int i = 0; i < 10; i++) cycle();
        check("cont_c_grants", n_c_gnt, 8);
        check("cont_d_grants", n_d_gnt, 2);
        check("cont_c_stalls", n_stall, 2);
        check("cont_d_pattern", d_win_pattern, 10'b10000_10000);
`ifdef DMEM_ARB_STATS_EN
        check("cont_stat_c", stat_c_grants, 32'd8);
        check("cont_stat_d", stat_d_grants, 32'd2);
        check("cont_stat_x", stat_conflicts, 32'd10);
`endif

        // Same-cycle c write and d read of one address: c first, d sees new data.
        drive(1, 1, 32'h4, 32'hAAAA_AAAA, 1, 0, 32'h4, 32'h0);
        cycle();
        drive(0, 0, 0, 0, 1, 0, 32'h4, 32'h0);
        cycle();
        check("d_read_after_c_wr", d_rdata, 32'hAAAA_AAAA);

        // Randomized traffic with hold-until-grant requesters and a mid-stream reset.
        c_pend = 0; d_pend = 0;
        for (int n = 0; n < 400; n++) begin
            if (n == 200 || n == 201) begin
                reset = 1'b1;
                c_pend = 0; d_pend = 0;
                drive(0, 0, 0, 0, 0, 0, 0, 0);
            end else begin
                reset = 1'b0;
                if (!c_pend && $urandom_range(0, 99) < 70) begin
                    c_pend = 1; c_w = 1'($urandom); c_a = {26'd0, 4'($urandom), 2'b00}; c_d = $urandom;
                end
                if (!d_pend && $urandom_range(0, 99) < 70) begin
                    d_pend = 1; d_w = 1'($urandom); d_a = {26'd0, 4'($urandom), 2'b00}; d_d = $urandom;
                end
                if (c_pend) begin
                    c_req = 1'b1; c_we = c_w; c_addr = c_a; c_wdata = c_d;
                end else begin
                    c_req = 1'b0; c_we = 1'($urandom); c_addr = $urandom; c_wdata = $urandom;
                end
                if (d_pend) begin
                    d_req = 1'b1; d_we = d_w; d_addr = d_a; d_wdata = d_d;
                end else begin
                    d_req = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
                end
            end
            cycle();
            if (m_c_gnt) c_pend = 0;
            if (m_d_gnt) d_pend = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
